// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings and FSM state type for muldiv_unit
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  function automatic logic op_is_signed(input logic [1:0] i_op);
    return (i_op == OP_MULT) || (i_op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] i_op);
    return (i_op == OP_DIV) || (i_op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_divstep.sv
// rtl/muldiv_divstep.sv - one combinational restoring-divide step
// Shifts the next dividend bit into the partial remainder and subtracts the divisor if it fits.
module muldiv_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;

  assign w_shift = {i_rem, i_bit};
  assign o_qbit  = (w_shift >= {1'b0, i_divisor});
  // When the divisor fits, the true difference is below 2^WIDTH, so the low bits are exact.
  assign w_diff  = w_shift[WIDTH-1:0] - i_divisor;
  assign o_rem   = o_qbit ? w_diff : w_shift[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MIPS-style HI/LO multiply/divide unit
// Optional macro MULDIV_FAST_MUL_EN: single-cycle multiply in CALC; divide stays iterative.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  muldiv_state_t    r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic             r_neg_res;
  logic             r_neg_rem;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_is_div;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_div_rem;
  logic             w_div_q;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_neg;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;
  logic             w_last;
  logic             w_calc_end;
  logic [WIDTH-1:0] w_mul_hi_nxt;
  logic [WIDTH-1:0] w_mul_lo_nxt;

  assign w_is_div = op_is_div(op);
  assign w_a_neg  = op_is_signed(op) & in1[WIDTH-1];
  assign w_b_neg  = op_is_signed(op) & in2[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -in1 : in1;
  assign w_b_mag  = w_b_neg ? -in2 : in2;

  muldiv_divstep #(
    .WIDTH(WIDTH)
  ) u_divstep (
    .i_rem    (r_acc_hi),
    .i_bit    (r_acc_lo[WIDTH-1]),
    .i_divisor(r_mcand),
    .o_rem    (w_div_rem),
    .o_qbit   (w_div_q)
  );

  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_neg = -w_prod;
  // Divide by zero leaves the raw dividend magnitude as remainder; only the quotient is forced.
  assign w_quo_fix  = r_div_zero ? '1 : (r_neg_res ? -r_acc_lo : r_acc_lo);
  assign w_rem_fix  = r_neg_rem ? -r_acc_hi : r_acc_hi;
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fast_prod;
  assign w_fast_prod  = {{WIDTH{1'b0}}, r_mcand} * {{WIDTH{1'b0}}, r_acc_lo};
  assign w_mul_hi_nxt = w_fast_prod[2*WIDTH-1:WIDTH];
  assign w_mul_lo_nxt = w_fast_prod[WIDTH-1:0];
  assign w_calc_end   = w_last | ~r_is_div;
`else
  logic [WIDTH:0] w_add;
  // Shift-add: conditionally add the multiplicand, then shift {carry, acc_hi, acc_lo} right.
  assign w_add        = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_mcand} : '0);
  assign w_mul_hi_nxt = w_add[WIDTH:1];
  assign w_mul_lo_nxt = {w_add[0], r_acc_lo[WIDTH-1:1]};
  assign w_calc_end   = w_last;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_div_zero <= 1'b0;
      r_acc_hi   <= '0;
      r_acc_lo   <= '0;
      r_mcand    <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (hi_we) r_hi <= wdata;
          if (lo_we) r_lo <= wdata;
          if (start) begin
            r_is_div   <= w_is_div;
            r_neg_res  <= w_a_neg ^ w_b_neg;
            r_neg_rem  <= w_a_neg;
            r_div_zero <= w_is_div && (in2 == '0);
            r_mcand    <= w_is_div ? w_b_mag : w_a_mag;
            r_acc_lo   <= w_is_div ? w_a_mag : w_b_mag;
            r_acc_hi   <= '0;
            r_cnt      <= '0;
            r_state    <= CALC;
          end
        end
        CALC: begin
          if (r_is_div) begin
            r_acc_hi <= w_div_rem;
            r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_div_q};
          end else begin
            r_acc_hi <= w_mul_hi_nxt;
            r_acc_lo <= w_mul_lo_nxt;
          end
          if (w_calc_end) begin
            r_cnt   <= '0;
            r_state <= FIX;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            {r_hi, r_lo} <= r_neg_res ? w_prod_neg : w_prod;
          end
          r_state <= DONE;
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state == CALC) || (r_state == FIX);
  assign done = (r_state == DONE);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit (honours MULDIV_FAST_MUL_EN and WIDTH override)
module tb_muldiv_unit;

  parameter int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH) + 1;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  localparam logic [1:0] T_MULT  = 2'b00;
  localparam logic [1:0] T_MULTU = 2'b01;
  localparam logic [1:0] T_DIV   = 2'b10;
  localparam logic [1:0] T_DIVU  = 2'b11;

  logic             clk = 1'b0;
  logic             reset, start, hi_we, lo_we;
  logic [1:0]       op;
  logic [WIDTH-1:0] in1, in2, wdata;
  logic             busy, done;
  logic [WIDTH-1:0] hi, lo;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [WIDTH-1:0] eh;
    logic [WIDTH-1:0] el;
    int               t0;
    int               lat;
  } exp_t;
  exp_t sb[$];

  muldiv_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .in1(in1), .in2(in2),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model(input logic [1:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                output logic [WIDTH-1:0] eh, output logic [WIDTH-1:0] el);
    logic signed [2*WIDTH-1:0] sa, sb_v, sr;
    logic [2*WIDTH-1:0] ur;
    sa = {{WIDTH{a[WIDTH-1]}}, a};
    sb_v = {{WIDTH{b[WIDTH-1]}}, b};
    eh = '0;
    el = '0;
    case (o)
      T_MULT: begin
        sr = sa * sb_v;
        {eh, el} = sr;
      end
      T_MULTU: begin
        ur = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        {eh, el} = ur;
      end
      T_DIV: begin
        if (b == '0) begin
          eh = a;
          el = '1;
        end else begin
          sr = sa / sb_v;
          el = sr[WIDTH-1:0];
          sr = sa % sb_v;
          eh = sr[WIDTH-1:0];
        end
      end
      default: begin
        if (b == '0) begin
          eh = a;
          el = '1;
        end else begin
          el = a / b;
          eh = a % b;
        end
      end
    endcase
  endfunction

  task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    logic [WIDTH-1:0] eh, el;
    model(o, a, b, eh, el);
    e.eh = eh;
    e.el = el;
    e.t0 = cyc;
    e.lat = (FAST && !o[1]) ? 3 : WIDTH + 2;
    sb.push_back(e);
    op = o;
    in1 = a;
    in2 = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
  endtask

  task automatic wait_done(input string name);
    exp_t e;
    bit seen;
    seen = 1'b0;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got empty queue, required one pending result", name);
    end else begin
      e = sb.pop_front();
      for (int i = 0; i < WIDTH + 10; i++) begin
        if (done === 1'b1) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (!seen) begin
        errors++;
        $display("FAIL %s done: got no pulse within %0d cycles, required one", name, WIDTH + 10);
      end else begin
        checks++;
        if (cyc - e.t0 !== e.lat) begin
          errors++;
          $display("FAIL %s latency: got %0d required %0d", name, cyc - e.t0, e.lat);
        end
        checks++;
        if (hi !== e.eh) begin
          errors++;
          $display("FAIL %s hi: got %h required %h", name, hi, e.eh);
        end
        checks++;
        if (lo !== e.el) begin
          errors++;
          $display("FAIL %s lo: got %h required %h", name, lo, e.el);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL %s done width: got %b on the following cycle, required 0", name, done);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    hi_we = 1'b1;
    lo_we = 1'b1;
    op = T_MULTU;
    in1 = '1;
    in2 = '1;
    wdata = '1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b required 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b required 0", done); end
    checks++;
    if (hi !== '0) begin errors++; $display("FAIL reset hi: got %h required 0", hi); end
    checks++;
    if (lo !== '0) begin errors++; $display("FAIL reset lo: got %h required 0", lo); end
  endtask

  task automatic test_spec_vectors();
    logic [WIDTH-1:0] ones, mn, m3, m7, m1, m2;
    ones = '1;
    mn = '0;
    mn[WIDTH-1] = 1'b1;
    m3 = WIDTH'(-3);
    m7 = WIDTH'(-7);
    m1 = WIDTH'(-1);
    m2 = WIDTH'(-2);
    issue(T_MULTU, ones, ones);            wait_done("multu_ones");
    issue(T_MULT, m3, WIDTH'(7));          wait_done("mult_neg3x7");
    issue(T_DIV, m7, WIDTH'(2));           wait_done("div_neg7by2");
    issue(T_DIVU, WIDTH'(7), '0);          wait_done("divu_by_zero");
    issue(T_DIV, mn, m1);                  wait_done("div_mostneg_by_m1");
    issue(T_DIV, m7, '0);                  wait_done("div_neg_by_zero");
    issue(T_DIV, WIDTH'(7), m2);           wait_done("div_7_by_neg2");
    issue(T_MULT, mn, mn);                 wait_done("mult_mostneg_sq");
    issue(T_DIVU, ones, WIDTH'(1));        wait_done("divu_ones_by_1");
  endtask

  task automatic test_mthi_mtlo();
    logic [WIDTH-1:0] va, vb, vc;
    va = WIDTH'(64'h1234_5678_9ABC_DEF0);
    vb = WIDTH'(64'h0FED_CBA9_8765_4321);
    vc = WIDTH'(64'hA5A5_5A5A_C3C3_3C3C);
    hi_we = 1'b1;
    wdata = va;
    @(negedge clk);
    hi_we = 1'b0;
    checks++;
    if (hi !== va) begin errors++; $display("FAIL mthi: got %h required %h", hi, va); end
    lo_we = 1'b1;
    wdata = vb;
    @(negedge clk);
    lo_we = 1'b0;
    checks++;
    if (lo !== vb) begin errors++; $display("FAIL mtlo: got %h required %h", lo, vb); end
    checks++;
    if (hi !== va) begin errors++; $display("FAIL mtlo_keeps_hi: got %h required %h", hi, va); end
    hi_we = 1'b1;
    wdata = vc;
    issue(T_MULTU, WIDTH'(5), WIDTH'(6));
    checks++;
    if (hi !== vc) begin errors++; $display("FAIL mthi_with_start: got %h required %h", hi, vc); end
    wait_done("multu_after_mthi");
  endtask

  task automatic test_busy_ignore();
    logic [WIDTH-1:0] hi0, lo0;
    int extra;
    hi0 = hi;
    lo0 = lo;
    issue(T_DIVU, WIDTH'(100), WIDTH'(7));
    start = 1'b1;
    op = T_MULT;
    in1 = WIDTH'(9);
    in2 = WIDTH'(11);
    hi_we = 1'b1;
    wdata = ~hi0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_flag: got %b required 1", busy); end
    checks++;
    if (hi !== hi0) begin errors++; $display("FAIL busy_hi_hold: got %h required %h", hi, hi0); end
    checks++;
    if (lo !== lo0) begin errors++; $display("FAIL busy_lo_hold: got %h required %h", lo, lo0); end
    start = 1'b0;
    hi_we = 1'b0;
    wait_done("divu_while_restarted");
    extra = 0;
    for (int i = 0; i < WIDTH + 6; i++) begin
      if (done === 1'b1) extra++;
      @(negedge clk);
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL busy_single_done: got %0d extra pulses required 0", extra); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    issue(T_DIVU, WIDTH'(64'hFFFF_0000_1234_5678), WIDTH'(3));
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(sb.pop_back());
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort busy: got %b required 0", busy); end
    checks++;
    if (hi !== '0) begin errors++; $display("FAIL abort hi: got %h required 0", hi); end
    checks++;
    if (lo !== '0) begin errors++; $display("FAIL abort lo: got %h required 0", lo); end
    pulses = 0;
    for (int i = 0; i < WIDTH + 6; i++) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL abort done: got %0d pulses required 0", pulses); end
    issue(T_MULT, WIDTH'(-3), WIDTH'(7));
    wait_done("mult_after_abort");
  endtask

  task automatic test_back_to_back();
    logic [63:0] ra, rb;
    logic [1:0] o;
    for (int n = 0; n < 16; n++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      o = 2'($urandom_range(0, 3));
      if (o[1] && ($urandom_range(0, 3) == 0)) rb = 64'($urandom_range(0, 5));
      issue(o, ra[WIDTH-1:0], rb[WIDTH-1:0]);
      wait_done("random_op");
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    op = 2'b00;
    in1 = '0;
    in2 = '0;
    wdata = '0;
    @(negedge clk);
    test_reset();
    test_spec_vectors();
    test_mthi_mtlo();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand, HI and LO width (8..64).
REQ-002 SHALL have parameter CNT_W, default 6: iteration counter width, at least clog2(WIDTH)+1.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to begin an operation.
REQ-006 SHALL have port op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 SHALL have port in1  input  WIDTH  multiplicand or dividend.
REQ-008 SHALL have port in2  input  WIDTH  multiplier or divisor.
REQ-009 SHALL have port hi_we  input  1  MTHI write strobe.
REQ-010 SHALL have port lo_we  input  1  MTLO write strobe.
REQ-011 SHALL have port wdata  input  WIDTH  MTHI/MTLO write data.
REQ-012 SHALL have port busy  output  1  operation in progress.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port hi  output  WIDTH  HI register: product upper half or remainder.
REQ-015 SHALL have port lo  output  WIDTH  LO register: product lower half or quotient.

Function
REQ-016 SHALL use the FSM states IDLE, CALC, FIX and DONE.
REQ-017 SHALL latch op, in1 and in2 on start in IDLE, then enter CALC with busy=1 from the next cycle.
REQ-018 SHALL ignore start while busy=1; operands are not re-latched.
REQ-019 SHALL run one shift-add (multiply) or restoring-subtract (divide) step per cycle for exactly WIDTH cycles in CALC, then enter FIX.
REQ-020 SHALL apply sign correction in FIX and write hi/lo, then enter DONE; DONE asserts done=1 for one cycle, drops busy, and returns to IDLE.
REQ-021 SHALL assert done exactly WIDTH+2 cycles after the start cycle, with hi/lo valid in the same cycle.
REQ-022 SHALL treat operands in signed ops as two's complement, work on magnitudes, then negate: product if the signs differ; quotient if the signs differ; remainder takes the sign of the dividend.
REQ-023 SHALL, on divide by zero, produce hi=in1 and lo=all-ones, with the same latency as any other divide.
REQ-024 SHALL, for DIV of most-negative by -1, produce lo=most-negative and hi=0.
REQ-025 SHALL apply hi_we/lo_we only in IDLE; strobes while busy are dropped.
REQ-026 SHALL, when start and a write strobe occur in the same IDLE cycle, apply the write now; the operation result later overwrites it.
REQ-027 SHALL keep hi/lo unchanged from start until FIX.

Reset
REQ-028 SHALL, on reset=1 at a clock edge, set state=IDLE, busy=0, done=0, hi=0, lo=0 and counter=0.
REQ-029 SHALL, on reset mid-operation, abort the operation with no done pulse; hi/lo read 0.
REQ-030 SHALL give reset priority over start and write strobes in the same cycle.

Configuration
REQ-031 SHALL recognise the macro MULDIV_FAST_MUL_EN.
REQ-032 SHALL, with MULDIV_FAST_MUL_EN defined, compute MULT/MULTU by a single-cycle full-width multiply in CALC (1 cycle), giving done 3 cycles after start; divide is unchanged.
REQ-033 SHALL, without MULDIV_FAST_MUL_EN, run all ops iteratively per REQ-019/REQ-021.

Structure
REQ-034 SHALL place in shared package muldiv_pkg: the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the state enum typedef.
REQ-035 SHALL implement one sub-module, muldiv_divstep: a combinational one-bit restoring-divide step (partial remainder, dividend bit, divisor -> new remainder, quotient bit).
REQ-036 SHALL keep the counter, sign flags and magnitude registers inside muldiv_unit.

Verification
REQ-037 SHALL cover: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done at cycle 34, hi=0xFFFFFFFE, lo=0x00000001.
REQ-038 SHALL cover: MULT -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-039 SHALL cover: DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7 / 0 -> lo=0xFFFFFFFF, hi=7.
REQ-040 SHALL cover: DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-041 SHALL cover: start while busy with different operands, plus hi_we while busy -> first result unchanged, a single done pulse, HI not written.
REQ-042 SHALL cover: reset at cycle 10 of a DIVU -> busy=0, hi=lo=0, no done; a new start then completes normally; the suite is repeated with WIDTH=16 and with MULDIV_FAST_MUL_EN defined (MULT done at cycle 3).
